// File: rtl/exe_mem.sv
// EX->MEM pipeline register: captures EX-stage control and data for the MEM stage.
// Latency: exactly 1 cycle; every output comes straight from a flop, with no combinational path.
// Backpressure: none. There is no stall, enable or flush; the register loads on every edge.
//
// Ports:
//   clk, rst (async active-low)
//   WriteRegIn/MemToRegIn/writeMemIn/BranchIn/zeroIn -> *Out : 1-bit control/flags
//   nextAddressIn -> nextAddressOut : ADDR_W branch target
//   ALUResultIn   -> ALUResultOut   : DATA_W ALU result / memory address
//   R2OutputIn    -> R2OutputOut    : R2_W second-operand field
//   registerIn    -> registerOut    : REG_W destination register number
module exe_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int R2_W   = 5,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteRegIn,
  output logic              WriteRegOut,
  input  logic              MemToRegIn,
  output logic              MemToRegOut,
  input  logic              writeMemIn,
  output logic              writeMemOut,
  input  logic              BranchIn,
  output logic              BranchOut,
  input  logic [ADDR_W-1:0] nextAddressIn,
  output logic [ADDR_W-1:0] nextAddressOut,
  input  logic              zeroIn,
  output logic              zeroOut,
  input  logic [DATA_W-1:0] ALUResultIn,
  output logic [DATA_W-1:0] ALUResultOut,
  input  logic [R2_W-1:0]   R2OutputIn,
  output logic [R2_W-1:0]   R2OutputOut,
  input  logic [REG_W-1:0]  registerIn,
  output logic [REG_W-1:0]  registerOut
);

  // All stage fields travel together as one packed payload.
  typedef struct packed {
    logic              write_reg;
    logic              mem_to_reg;
    logic              write_mem;
    logic              branch;
    logic [ADDR_W-1:0] next_addr;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [R2_W-1:0]   r2_output;
    logic [REG_W-1:0]  dest_reg;
  } ex_mem_t;

  ex_mem_t stage_d;
  ex_mem_t stage_q;

  always_comb begin
    stage_d            = '0;
    stage_d.write_reg  = WriteRegIn;
    stage_d.mem_to_reg = MemToRegIn;
    stage_d.write_mem  = writeMemIn;
    stage_d.branch     = BranchIn;
    stage_d.next_addr  = nextAddressIn;
    stage_d.zero       = zeroIn;
    stage_d.alu_result = ALUResultIn;
    stage_d.r2_output  = R2OutputIn;
    stage_d.dest_reg   = registerIn;
  end

  // Reset clears the stage at once and discards any in-flight instruction.
  // Deassertion is not synchronised in this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign WriteRegOut    = stage_q.write_reg;
  assign MemToRegOut    = stage_q.mem_to_reg;
  assign writeMemOut    = stage_q.write_mem;
  assign BranchOut      = stage_q.branch;
  assign nextAddressOut = stage_q.next_addr;
  assign zeroOut        = stage_q.zero;
  assign ALUResultOut   = stage_q.alu_result;
  assign R2OutputOut    = stage_q.r2_output;
  assign registerOut    = stage_q.dest_reg;

endmodule

// File: tb/tb_exe_mem.sv
// Bench for exe_mem: a scoreboard of expected stage contents, filled by the stimulus process.
// Latency modelled: whatever is applied before a rising edge with rst high appears just after that edge.
// Backpressure: none; a monitor drains one expected entry per rising edge.
module tb_exe_mem;

  typedef struct packed {
    logic        wr;
    logic        m2r;
    logic        wm;
    logic        br;
    logic [31:0] na;
    logic        z;
    logic [31:0] alu;
    logic [4:0]  r2;
    logic [4:0]  rg;
  } bundle_t;

  logic    clk;
  logic    rst;
  bundle_t in_s;
  bundle_t out_s;
  bundle_t exp_q[$];
  int      n_checks;
  int      n_fail;

  exe_mem #(.ADDR_W(32), .DATA_W(32), .R2_W(5), .REG_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .WriteRegIn     (in_s.wr),
    .WriteRegOut    (out_s.wr),
    .MemToRegIn     (in_s.m2r),
    .MemToRegOut    (out_s.m2r),
    .writeMemIn     (in_s.wm),
    .writeMemOut    (out_s.wm),
    .BranchIn       (in_s.br),
    .BranchOut      (out_s.br),
    .nextAddressIn  (in_s.na),
    .nextAddressOut (out_s.na),
    .zeroIn         (in_s.z),
    .zeroOut        (out_s.z),
    .ALUResultIn    (in_s.alu),
    .ALUResultOut   (out_s.alu),
    .R2OutputIn     (in_s.r2),
    .R2OutputOut    (out_s.r2),
    .registerIn     (in_s.rg),
    .registerOut    (out_s.rg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input bundle_t act, input bundle_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.wr  = 1'($urandom);
    b.m2r = 1'($urandom);
    b.wm  = 1'($urandom);
    b.br  = 1'($urandom);
    b.na  = $urandom;
    b.z   = 1'($urandom);
    b.alu = $urandom;
    b.r2  = 5'($urandom);
    b.rg  = 5'($urandom);
    return b;
  endfunction

  // Reference model: a register captures its input on each rising edge with rst high.
  task automatic drive(input bundle_t v);
    @(negedge clk);
    in_s = v;
    exp_q.push_back(v);
  endtask

  // Monitor: after each capturing edge, the outputs must equal the oldest pending entry.
  initial begin
    bundle_t e;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("capture", out_s, e);
        end
      end
    end
  end

  initial begin
    bundle_t v;
    bundle_t zero_b;
    zero_b   = '0;
    n_checks = 0;
    n_fail   = 0;

    // Reset held low: nonzero inputs are ignored across several edges.
    rst  = 1'b0;
    in_s = rand_bundle();
    in_s.rg  = 5'd7;
    in_s.alu = in_s.alu | 32'h1;
    #1 chk("reset_state", out_s, zero_b);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("reset_hold", out_s, zero_b);
    end

    // Release reset with all-zero inputs.
    @(negedge clk);
    rst  = 1'b1;
    in_s = '0;
    exp_q.push_back(zero_b);

    // Known pattern; before the edge the outputs are still zero.
    v = '{wr: 1'b1, m2r: 1'b1, wm: 1'b1, br: 1'b1, na: 32'd2, z: 1'b1,
          alu: 32'd3, r2: 5'd4, rg: 5'd5};
    drive(v);
    #1 chk("pre_edge", out_s, zero_b);

    // Max register number passes unchanged.
    v.rg = 5'd31;
    drive(v);
    // A mid-cycle input change stays invisible until the next edge.
    @(negedge clk);
    #2;
    in_s.alu = 32'hFFFF_FFFF;
    exp_q.push_back(in_s);
    #1 chk("mid_cycle_hold", out_s, v);
    #1 chk("mid_cycle_hold2", out_s, v);

    // Asynchronous reset between edges while the outputs are nonzero.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1 chk("async_reset", out_s, zero_b);
    @(posedge clk);
    #1 chk("reset_ignores_clk", out_s, zero_b);
    @(negedge clk);
    rst  = 1'b1;
    in_s = rand_bundle();
    exp_q.push_back(in_s);

    // Back-to-back register numbers 1,2,3.
    for (int k = 1; k <= 3; k++) begin
      v    = rand_bundle();
      v.rg = 5'(k);
      drive(v);
    end

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1 chk("rand_reset", out_s, zero_b);
        @(posedge clk);
        #1 chk("rand_reset_hold", out_s, zero_b);
        @(negedge clk);
        rst = 1'b1;
      end
      drive(rand_bundle());
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
